instr_fetch_queue: RTL and testbench

Fetch stage directly upstream of `decoder`. It generates sequential instruction addresses, issues them to a synchronous instruction memory, and buffers returned instructions in a small queue. It presents instructions to decode over a valid/ready handshake. A redirect input flushes the queue and squashes any in-flight fetch.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instr_fetch_queue.sv | 90 +++++++++
 tb/tb_instr_fetch_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared widths, default reset PC and queue entry type
// Rev 1.0
// ============================================================================
package fetch_pkg;

  localparam int ADDR_W      = 32;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : synchronous FIFO of fetch entries with flush and occupancy
// Rev 1.0
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (r_count <= CNT_W'(DEPTH));
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// instr_fetch_queue : sequential fetch, credit-limited issue, redirect flush
// Rev 1.0
// ============================================================================
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       PCWre,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_instr,
  output logic [INSTR_W-1:0]         instr,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_kill;

  logic [CNT_W:0]    w_used;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_redirect_pc;
  fetch_entry_t      w_push_data;
  fetch_entry_t      w_head;

  // The in-flight fetch holds a credit so a return can never overflow the queue.
  assign w_used        = {1'b0, count} + (CNT_W+1)'(r_inflight);
  assign imem_req      = !Reset && PCWre && !redirect && (w_used < (CNT_W+1)'(DEPTH));
  assign imem_addr     = r_pc;
  assign w_redirect_pc = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_kill        <= 1'b0;
    end else if (redirect) begin
      r_pc       <= w_redirect_pc;
      r_inflight <= 1'b0;
      r_kill     <= r_inflight;
    end else begin
      r_inflight <= imem_req;
      r_kill     <= 1'b0;
      if (imem_req) begin
        r_pc          <= r_pc + ADDR_W'(INSTR_BYTES);
        r_inflight_pc <= r_pc;
      end
    end
  end

  assign w_push            = r_inflight && !r_kill;
  assign w_pop             = instr_valid && instr_ready;
  assign w_push_data.instr = imem_instr;
  assign w_push_data.pc    = r_inflight_pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (Reset),
    .flush     (redirect),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (count)
  );

  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign instr_valid = (count != '0);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_queue : directed stimulus, queue-based reference model
// Rev 1.0
// ============================================================================
module tb_instr_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pcwre, redirect, ready;
  logic [31:0] redirect_pc;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, imem_instr, instr, instr_pc;
  logic [$clog2(DEPTH+1)-1:0] count;

  logic        req2, valid2;
  logic [31:0] addr2, mem2, instr2, pc2;
  logic [$clog2(DEPTH+1)-1:0] count2;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK(clk), .Reset(rst), .PCWre(pcwre), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(ready), .count(count)
  );

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .CLK(clk), .Reset(rst), .PCWre(1'b1), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(req2), .imem_addr(addr2),
    .imem_instr(mem2), .instr(instr2), .instr_pc(pc2),
    .instr_valid(valid2), .instr_ready(1'b1), .count(count2)
  );

  // Memory returns a tagged copy of the address one cycle after a request.
  always @(posedge clk) begin
    imem_instr <= imem_req ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
    mem2       <= req2 ? (addr2 ^ KEY) : 32'hDEAD_BEEF;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of expected PCs plus one pending memory return.
  logic [31:0] q_pc[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_pend_pc = 32'h0;
  bit          m_pend = 1'b0;
  bit          m_init = 1'b0;

  always @(negedge clk) begin : model
    bit exp_req;
    int n;
    n       = q_pc.size();
    exp_req = !rst && pcwre && !redirect && ((n + int'(m_pend)) < DEPTH);
    if (m_init) begin
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) check("imem_addr", imem_addr, m_pc);
      check("count", 32'(count), 32'(n));
      check("instr_valid", 32'(instr_valid), 32'(n != 0));
      if (n != 0) begin
        check("instr_pc", instr_pc, q_pc[0]);
        check("instr", instr, q_pc[0] ^ KEY);
      end
    end
    if (rst) begin
      q_pc.delete();
      m_pc   = 32'h0;
      m_pend = 1'b0;
      m_init = 1'b1;
    end else if (m_init) begin
      if (redirect) begin
        q_pc.delete();
        m_pc   = redirect_pc & ~32'h3;
        m_pend = 1'b0;
      end else begin
        if (n != 0 && ready) void'(q_pc.pop_front());
        if (m_pend) q_pc.push_back(m_pend_pc);
        m_pend = exp_req;
        if (exp_req) begin
          m_pend_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [23:0] READY_PAT = 24'b1011_0010_1110_0111_0100_1101;
  localparam logic [23:0] PCWRE_PAT = 24'b1111_0111_1101_1111_1011_1110;

  initial begin
    logic [23:0] rp, pp;
    rp = READY_PAT;
    pp = PCWRE_PAT;
    rst = 1'b1; pcwre = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b0;
    step(3);

    // Streaming from reset: one instruction per cycle from cycle 2.
    rst = 1'b0; pcwre = 1'b1; ready = 1'b1;
    step(2);
    check("c2_valid", 32'(instr_valid), 32'h1);
    check("c2_pc", instr_pc, 32'h0);
    check("c2_instr", instr, 32'hA5A5_0000);
    check("wrap_pc0", pc2, 32'hFFFF_FFF8);
    step(1);
    check("c3_pc", instr_pc, 32'h4);
    check("wrap_pc1", pc2, 32'hFFFF_FFFC);
    step(1);
    check("c4_pc", instr_pc, 32'h8);
    check("wrap_pc2", pc2, 32'h0);
    check("wrap_instr2", instr2, 32'hA5A5_0000);
    step(3);

    // Fill to three entries with a fetch in flight, then pulse reset.
    ready = 1'b0;
    step(2);
    check("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    step(1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", imem_addr, 32'h0);
    step(1);
    check("no_stale_push", 32'(count), 32'd0);

    // Back-pressure: issue stops at four credits, then drains in order.
    step(9);
    check("sat_count", 32'(count), 32'd4);
    check("sat_req", 32'(imem_req), 32'd0);
    ready = 1'b1;
    check("drain_pc0", instr_pc, 32'h0);
    step(1);
    check("drain_pc1", instr_pc, 32'h4);
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", imem_addr, 32'h10);
    step(1);
    check("drain_pc2", instr_pc, 32'h8);
    step(1);
    check("drain_pc3", instr_pc, 32'hC);
    step(1);
    check("drain_pc4", instr_pc, 32'h10);

    // Redirect with a fetch in flight.
    ready = 1'b0;
    step(1);
    check("pre_redir_count", 32'(count), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    check("redir_req", 32'(imem_req), 32'd0);
    step(1);
    check("redir_count", 32'(count), 32'd0);
    check("redir_valid", 32'(instr_valid), 32'd0);
    redirect = 1'b0; ready = 1'b1;
    #1;
    check("redir_addr", imem_addr, 32'h100);
    step(1);
    check("redir_r2_valid", 32'(instr_valid), 32'd0);
    step(1);
    check("redir_r3_valid", 32'(instr_valid), 32'd1);
    check("redir_r3_pc", instr_pc, 32'h100);
    check("redir_r3_instr", instr, 32'hA5A5_0100);

    // Fetch enable low for three cycles mid-stream.
    step(2);
    pcwre = 1'b0;
    #1;
    check("stall_req0", 32'(imem_req), 32'd0);
    step(1);
    check("stall_req1", 32'(imem_req), 32'd0);
    step(1);
    check("stall_req2", 32'(imem_req), 32'd0);
    check("stall_count", 32'(count), 32'd0);
    step(1);
    pcwre = 1'b1;
    #1;
    check("stall_resume_addr", imem_addr, 32'h110);

    // Redirect while full, same-cycle pop discarded; then mixed traffic.
    ready = 1'b0;
    step(8);
    check("full_count", 32'(count), 32'd4);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; ready = 1'b1;
    step(1);
    check("full_redir_count", 32'(count), 32'd0);
    redirect = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ready = rp[i];
      pcwre = pp[i];
      if (i == 12) begin
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF6;
      end else begin
        redirect = 1'b0;
      end
      step(1);
    end
    redirect = 1'b0; ready = 1'b1; pcwre = 1'b1;
    step(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
